// File: rtl/switch_pkg.sv
// Shared types and defaults for the DIP-switch input path.
package switch_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } sw_state_e;

  localparam int SW_WIDTH              = 24;
  localparam int DEFAULT_STABLE_CYCLES = 200000;
  localparam int DEFAULT_CNT_W         = 20;

endpackage

// File: rtl/sync2_ff.sv
// Two-flop synchroniser for asynchronous board inputs (switches, buttons).
module sync2_ff
  import switch_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  // Plain flop-to-flop chain so the first stage gets a full cycle to resolve.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/switch_debouncer.sv
// Synchronises and debounces the DIP-switch vector; commits a new value only
// after it has been observed unchanged for STABLE_CYCLES consecutive cycles.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int WIDTH         = SW_WIDTH,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic             switclk,
  input  logic             switchrst,
  input  logic [WIDTH-1:0] switch_raw,
  output logic [WIDTH-1:0] switch_input,
  output logic             sw_changed,
  output logic             sw_settling
);

  if ((STABLE_CYCLES < 32'sd1) || (STABLE_CYCLES > 32'sd1048575)) begin : g_bad_stable_cycles
    $error("switch_debouncer: STABLE_CYCLES must be in 1 .. 2^20-1");
  end

  if ((CNT_W < 32'sd1) || (CNT_W > 32'sd30) || ((32'sd1 << CNT_W) <= STABLE_CYCLES)) begin : g_bad_cnt_w
    $error("switch_debouncer: CNT_W too small for STABLE_CYCLES");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync2;
  sw_state_e        state_q;
  logic [WIDTH-1:0] cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] out_q;
  logic             changed_q;
  logic             settling_q;

  sync2_ff #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk_i (switclk),
    .rst_i (switchrst),
    .d_i   (switch_raw),
    .q_o   (sync2)
  );

  // Debounce FSM; any bit differing from the candidate restarts the whole window.
  always_ff @(posedge switclk or posedge switchrst) begin
    if (switchrst) begin
      state_q    <= STABLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      changed_q  <= 1'b0;
      settling_q <= 1'b0;
    end else begin
      changed_q <= 1'b0;
      case (state_q)
        STABLE: begin
          if (sync2 != out_q) begin
            cand_q     <= sync2;
            cnt_q      <= '0;
            state_q    <= SETTLING;
            settling_q <= 1'b1;
          end
        end
        SETTLING: begin
          if (sync2 != cand_q) begin
            cand_q <= sync2;
            cnt_q  <= '0;
          end else if (cnt_q == CNT_LAST) begin
            // A bounce back to the committed value still runs the full window.
            out_q      <= cand_q;
            changed_q  <= (cand_q != out_q);
            state_q    <= STABLE;
            settling_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q    <= STABLE;
          settling_q <= 1'b0;
        end
      endcase
    end
  end

  assign switch_input = out_q;
  assign sw_changed   = changed_q;
  assign sw_settling  = settling_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomised and directed bench for switch_debouncer; two instances
// (STABLE_CYCLES = 4 and 1) are checked against a queue-based window model.
module tb_switch_debouncer;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] raw;
  logic [23:0] out4, out1;
  logic        chg4, chg1, set4, set1;

  always #5 clk = ~clk;

  switch_debouncer #(.WIDTH(24), .STABLE_CYCLES(4), .CNT_W(20)) u_dut4 (
    .switclk(clk), .switchrst(rst), .switch_raw(raw),
    .switch_input(out4), .sw_changed(chg4), .sw_settling(set4)
  );

  switch_debouncer #(.WIDTH(24), .STABLE_CYCLES(1), .CNT_W(20)) u_dut1 (
    .switclk(clk), .switchrst(rst), .switch_raw(raw),
    .switch_input(out1), .sw_changed(chg1), .sw_settling(set1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;
  int pulses4, pulses1, last_chg4, last_chg1, rise4;
  logic prev_set4, saw_set4;

  // Reference model: a two-sample delay line feeding a window of identical observations.
  logic [23:0] m_d1, m_d2;
  logic [23:0] m_out [2];
  logic        m_chg [2];
  logic        m_set [2];
  logic [23:0] win0 [$];
  logic [23:0] win1 [$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_d1 = 24'h0;
    m_d2 = 24'h0;
    for (int i = 0; i < 2; i++) begin
      m_out[i] = 24'h0;
      m_chg[i] = 1'b0;
      m_set[i] = 1'b0;
    end
    win0 = {};
    win1 = {};
  endtask

  // A value is committed once STABLE_CYCLES+1 identical observations have been collected.
  task automatic model_fsm(input int i, input int s, input logic [23:0] obs);
    logic [23:0] w [$];
    if (i == 0) w = win0; else w = win1;
    m_chg[i] = 1'b0;
    if (!m_set[i]) begin
      if (obs != m_out[i]) begin
        m_set[i] = 1'b1;
        w = {obs};
      end
    end else begin
      if (obs != w[0]) w = {obs};
      else w.push_back(obs);
      if (w.size() == s + 1) begin
        m_chg[i] = (w[0] != m_out[i]);
        m_out[i] = w[0];
        m_set[i] = 1'b0;
        w = {};
      end
    end
    if (i == 0) win0 = w; else win1 = w;
  endtask

  task automatic model_edge();
    logic [23:0] obs;
    if (!rst) begin
      obs  = m_d2;
      m_d2 = m_d1;
      m_d1 = raw;
      model_fsm(0, 4, obs);
      model_fsm(1, 1, obs);
    end
  endtask

  task automatic compare_all();
    check_val("out4", 32'(out4), 32'(m_out[0]));
    check_val("chg4", 32'(chg4), 32'(m_chg[0]));
    check_val("set4", 32'(set4), 32'(m_set[0]));
    check_val("out1", 32'(out1), 32'(m_out[1]));
    check_val("chg1", 32'(chg1), 32'(m_chg[1]));
    check_val("set1", 32'(set1), 32'(m_set[1]));
    if (chg4) begin pulses4++; last_chg4 = edge_n; end
    if (chg1) begin pulses1++; last_chg1 = edge_n; end
    if (set4 && !prev_set4) rise4 = edge_n;
    if (set4) saw_set4 = 1'b1;
    prev_set4 = set4;
  endtask

  task automatic tick(input logic [23:0] v, input logic r = 1'b0);
    @(negedge clk);
    raw = v;
    rst = r;
    if (r) model_reset();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic assert_rst_now();
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
  endtask

  task automatic clear_stats();
    pulses4  = 0;
    pulses1  = 0;
    last_chg4 = -100;
    last_chg1 = -100;
    rise4    = -100;
    saw_set4 = 1'b0;
  endtask

  initial begin
    int k0;
    logic [23:0] v;
    rst = 1'b1;
    raw = 24'hFFFFFF;
    prev_set4 = 1'b0;
    model_reset();
    clear_stats();

    // Reset with all switches on, then release with input steady.
    repeat (3) tick(24'hFFFFFF, 1'b1);
    check_val("rst_out4", 32'(out4), 32'h0);
    check_val("rst_set4", 32'(set4), 32'h0);
    k0 = edge_n + 1;
    repeat (10) tick(24'hFFFFFF);
    check_val("rst_commit_lat4", 32'(last_chg4 - k0), 32'd6);
    check_val("rst_pulses4", 32'(pulses4), 32'd1);
    check_val("rst_final4", 32'(out4), 32'hFFFFFF);

    // Clean change 0 -> 00A5C3.
    repeat (2) tick(24'h0, 1'b1);
    repeat (3) tick(24'h0);
    clear_stats();
    k0 = edge_n + 1;
    repeat (10) tick(24'h00A5C3);
    check_val("clean_rise4", 32'(rise4 - k0), 32'd2);
    check_val("clean_lat4", 32'(last_chg4 - k0), 32'd6);
    check_val("clean_lat1", 32'(last_chg1 - k0), 32'd3);
    check_val("clean_pulses4", 32'(pulses4), 32'd1);
    check_val("clean_out4", 32'(out4), 32'h00A5C3);

    // Bit 0 bouncing in 2-cycle phases, finally held high.
    repeat (2) tick(24'h0, 1'b1);
    repeat (3) tick(24'h0);
    clear_stats();
    k0 = 0;
    for (int c = 0; c < 10; c++) begin
      tick((((c / 2) % 2) == 0) ? 24'h000001 : 24'h000000);
      if (c == 8) k0 = edge_n;
    end
    repeat (12) tick(24'h000001);
    check_val("bounce_pulses4", 32'(pulses4), 32'd1);
    check_val("bounce_lat4", 32'(last_chg4 - k0), 32'd6);
    check_val("bounce_out4", 32'(out4), 32'h000001);

    // Glitch on bit 23 that returns to the committed value.
    repeat (2) tick(24'h0, 1'b1);
    repeat (3) tick(24'h0);
    clear_stats();
    repeat (2) tick(24'h800000);
    repeat (12) tick(24'h000000);
    check_val("bback_pulses4", 32'(pulses4), 32'd0);
    check_val("bback_saw_set4", 32'(saw_set4), 32'd1);
    check_val("bback_set4_end", 32'(set4), 32'd0);
    check_val("bback_out4", 32'(out4), 32'h0);

    // Reset while a new candidate is being timed.
    repeat (2) tick(24'h0, 1'b1);
    repeat (12) tick(24'h000011);
    check_val("mid_pre_out4", 32'(out4), 32'h000011);
    clear_stats();
    k0 = edge_n + 1;
    repeat (5) tick(24'h000022);
    check_val("mid_rise4", 32'(rise4 - k0), 32'd2);
    assert_rst_now();
    check_val("mid_rst_out4", 32'(out4), 32'h0);
    check_val("mid_rst_set4", 32'(set4), 32'h0);
    repeat (2) tick(24'h000022, 1'b1);
    clear_stats();
    k0 = edge_n + 1;
    repeat (10) tick(24'h000022);
    check_val("mid_relat4", 32'(last_chg4 - k0), 32'd6);
    check_val("mid_out4", 32'(out4), 32'h000022);

    // Two bits change in the same cycle: one vector change, one commit each.
    repeat (2) tick(24'h0, 1'b1);
    repeat (3) tick(24'h0);
    clear_stats();
    repeat (10) tick(24'h000300);
    check_val("multi_pulses4", 32'(pulses4), 32'd1);
    check_val("multi_pulses1", 32'(pulses1), 32'd1);
    check_val("multi_out1", 32'(out1), 32'h000300);

    // Random stimulus: mostly steady with bursts of bounces and occasional resets.
    v = 24'h0;
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        repeat (2) tick(v, 1'b1);
      end else begin
        if (r < 12) v = 24'($urandom());
        else if (r < 30) v = v ^ (24'h000001 << $urandom_range(0, 23));
        tick(v);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Sits directly upstream of the Switch MMIO read block.
- Takes the raw 24-bit DIP-switch pins from the board and synchronises them into the CPU clock domain.
- Debounces the whole vector and drives a clean, registered `switch_input` bus that the Switch block samples on the negedge.
- Also provides a one-cycle change pulse and a settling status bit for optional interrupt/poll use.

Parameters:
- WIDTH, 24: number of switch bits.
- STABLE_CYCLES, 200000: consecutive cycles the synchronised vector must stay unchanged before it is committed; legal range 1 to 2^20-1, elaboration error outside this range.
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- switclk  in  1  CPU clock; all state updates on posedge.
- switchrst  in  1  reset, asynchronous, active-high.
- switch_raw  in  WIDTH  raw, asynchronous, bouncing switch pins.
- switch_input  out  WIDTH  debounced vector, registered; feeds Switch.switch_input.
- sw_changed  out  1  single-cycle pulse when switch_input takes a new value.
- sw_settling  out  1  high while a candidate value is being timed.

Behaviour:
- Reset (switchrst high, asynchronous, no clock required):
  - sync1, sync2, candidate, switch_input all 0.
  - cnt 0, state STABLE.
  - sw_changed 0, sw_settling 0.
- Synchroniser: sync1 <= switch_raw; sync2 <= sync1. No logic between the two flops.
- FSM, evaluated on posedge with sync2 as the observed value:
  - STABLE, sync2 == switch_input: hold all state.
  - STABLE, sync2 != switch_input: candidate <= sync2, cnt <= 0, go to SETTLING.
  - SETTLING, sync2 != candidate: candidate <= sync2, cnt <= 0, stay in SETTLING. This is the bounce restart.
  - SETTLING, sync2 == candidate and cnt == STABLE_CYCLES-1: switch_input <= candidate, go to STABLE. sw_changed <= 1 only if candidate != switch_input.
  - SETTLING, otherwise: cnt <= cnt+1.
- sw_changed is registered, high for exactly one cycle, and 0 in every other cycle.
- sw_settling is registered and equals (state == SETTLING).
- Latency: raw changes before edge k and stays steady. sync2 valid after edge k+1; SETTLING entered at edge k+2; switch_input updates at edge k+2+STABLE_CYCLES, with sw_changed high in the same cycle.
- Bounce back to the original value: the candidate becomes equal to switch_input again and the FSM still waits the full window. At commit switch_input is unchanged, sw_changed stays 0, and the FSM returns to STABLE.
- Multi-bit changes are handled as one vector: any bit toggling restarts the window for all bits. No per-bit partial commits.
- STABLE_CYCLES == 1: commit occurs on the first SETTLING cycle where sync2 matches the candidate.
- cnt never exceeds STABLE_CYCLES-1; no wrap-around is possible.
- Reset mid-SETTLING: the pending candidate is discarded and switch_input returns to 0 immediately.
- Output timing: switch_input changes only on posedge, so it is stable across the negedge on which Switch samples. No extra staging is required.

Decomposition:
- Shared package switch_pkg:
  - state typedef (STABLE=1'b0, SETTLING=1'b1);
  - SW_WIDTH = 24;
  - DEFAULT_STABLE_CYCLES = 200000.
- One natural sub-module: sync2_ff, a parameterised WIDTH two-flop synchroniser with switchrst async clear. Instantiated once here and reusable for the button inputs.

Test Plan (bench uses STABLE_CYCLES=4 unless stated):
- Reset: hold switchrst with switch_raw=24'hFFFFFF -> switch_input=0, sw_changed=0, sw_settling=0. After release with input steady: switch_input=24'hFFFFFF at edge 2+4=6, with one sw_changed pulse.
- Clean change: switch_raw 0 -> 24'h00A5C3 before edge k, then steady -> sw_settling high from k+2; switch_input=24'h00A5C3 and sw_changed=1 exactly at edge k+6; sw_changed=0 at k+7.
- Bounce: toggle bit 0 every 2 cycles for 10 cycles, then hold at 1 -> no commit while toggling; commit occurs 2+4 edges after the last toggle; exactly one sw_changed pulse.
- Bounce back: pulse bit 23 high for 2 cycles, then return low -> sw_settling asserts; switch_input stays 24'h000000; sw_changed never asserts; FSM ends in STABLE.
- Reset mid-settle: with switch_input=24'h000011, change raw to 24'h000022 and assert switchrst 2 cycles after sw_settling rises -> switch_input=0 and sw_settling=0 at once. After release, 24'h000022 commits 6 edges later.
- Boundary STABLE_CYCLES=1: a steady change commits at edge k+3. Raw change and an unrelated bit toggle in the same cycle -> treated as one vector change, single commit.
